// File: rtl/accumulate_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | accumulate      : shared signed-magnitude add/subtract datapath          |
// | accumulate_seq  : sequential multiply-accumulate controller.             |
// |                   Takes a stream of signed-magnitude mantissa products,  |
// |                   keeps a running sum with a right-shift count that      |
// |                   absorbs carry-out, and hands the result to the         |
// |                   normalise/round stage.                                 |
// | Revision        : 1.0  initial release                                   |
// +--------------------------------------------------------------------------+

// Magnitude adder/subtractor. In subtract mode it returns |ab - c| together
// with the comparison flags the caller needs to pick the result sign.
module accumulate #(
  parameter int W = 48
) (
  input  logic [W-1:0] ab,
  input  logic [W-1:0] c,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         ab_gt_c,
  output logic         equal
);

  logic [W:0] sum_ext;

  // Add with carry-out, or subtract the smaller magnitude from the larger.
  always_comb begin
    sum_ext = {1'b0, ab} + {1'b0, c};
    ab_gt_c = (ab > c);
    equal   = (ab == c);
    ovf     = 1'b0;
    if (sub) begin
      if (ab_gt_c) result = ab - c;
      else         result = c - ab;
    end else begin
      result = sum_ext[W-1:0];
      ovf    = sum_ext[W];
    end
  end

endmodule

module accumulate_seq #(
  parameter int size_mantissa     = 24,
  parameter int size_counter      = 5,
  parameter int size_mul_mantissa = size_mantissa + size_mantissa
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [size_mul_mantissa-1:0] ab_number_i,
  input  logic                         ab_sign_i,
  input  logic                         last_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [size_mul_mantissa-1:0] acc_number_o,
  output logic                         acc_sign_o,
  output logic [size_counter-1:0]      acc_shift_o,
  output logic                         acc_zero_o,
  output logic                         busy_o
);

  localparam int W = size_mul_mantissa;
  localparam logic [size_counter-1:0] SHIFT_MAX = '1;
  localparam logic [size_counter-1:0] SHIFT_ONE = size_counter'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [W-1:0]            acc_mag;
  logic                    acc_sign;
  logic [size_counter-1:0] acc_shift;

  logic [W-1:0]            aligned;
  logic                    dp_sub;
  logic [W-1:0]            dp_result;
  logic                    dp_ovf;
  logic                    dp_ab_gt_c;
  logic                    dp_equal;

  logic [W-1:0]            mag_nxt;
  logic                    sign_nxt;
  logic [size_counter-1:0] shift_nxt;

  logic                    accept;

  // Next-state and handshake outputs; only ACCUM takes operands and only
  // DONE offers a result, so start_i is looked at in IDLE alone.
  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready_o = 1'b1;
        if (in_valid_i && last_i) state_nxt = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign accept = in_valid_i && in_ready_o;

  // Bring the incoming product onto the accumulator's scale; shifting past
  // the full width leaves nothing.
  always_comb begin
    if (int'(acc_shift) >= W) aligned = '0;
    else                      aligned = ab_number_i >> acc_shift;
  end

  assign dp_sub = ab_sign_i ^ acc_sign;

  accumulate #(
    .W (W)
  ) u_accumulate (
    .ab      (aligned),
    .c       (acc_mag),
    .sub     (dp_sub),
    .result  (dp_result),
    .ovf     (dp_ovf),
    .ab_gt_c (dp_ab_gt_c),
    .equal   (dp_equal)
  );

  // Fold the datapath result into the new accumulator: a carry drops the LSB
  // and bumps the shift count (or saturates once the count is exhausted),
  // a subtraction takes the sign of the larger magnitude, zero is positive.
  always_comb begin
    mag_nxt   = dp_result;
    sign_nxt  = acc_sign;
    shift_nxt = acc_shift;
    if (dp_ovf) begin
      if (acc_shift == SHIFT_MAX) begin
        mag_nxt = '1;
      end else begin
        mag_nxt   = {1'b1, dp_result[W-1:1]};
        shift_nxt = acc_shift + SHIFT_ONE;
      end
    end else if (dp_sub) begin
      if (dp_equal)        sign_nxt = 1'b0;
      else if (dp_ab_gt_c) sign_nxt = ab_sign_i;
      else                 sign_nxt = acc_sign;
    end
    if (mag_nxt == '0) sign_nxt = 1'b0;
  end

  // Accumulator registers: cleared when a run starts, updated per accepted
  // operand, otherwise held (including after the result has been taken).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_mag   <= '0;
      acc_sign  <= 1'b0;
      acc_shift <= '0;
    end else if (state == IDLE && start_i) begin
      acc_mag   <= '0;
      acc_sign  <= 1'b0;
      acc_shift <= '0;
    end else if (accept) begin
      acc_mag   <= mag_nxt;
      acc_sign  <= sign_nxt;
      acc_shift <= shift_nxt;
    end
  end

  assign acc_number_o = acc_mag;
  assign acc_zero_o   = (acc_mag == '0);
  assign acc_sign_o   = acc_sign & ~acc_zero_o;
  assign acc_shift_o  = acc_shift;

endmodule
`default_nettype wire
